alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares a single 32-bit ALU between two requesters, e.g. a main datapath port and a debug/coprocessor port. Each requester issues operand pairs plus a 3-bit ALU opcode over a valid/ready request channel. The block grants one request at a time using round-robin priority, registers operands and result, and returns result plus zero flag over a per-requester valid/ready response channel. It sits between requester logic and the ALU; the ALU itself stays purely combinational.

## Interface
- INIT_PRIORITY, 0: requester holding priority after reset (0 or 1).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid_0 / req_valid_1  in  1  request present on port 0 / 1.
- req_ready_0 / req_ready_1  out  1  request accepted this cycle.
- req_a_0 / req_a_1  in  32  operand A.
- req_b_0 / req_b_1  in  32  operand B.
- req_op_0 / req_op_1  in  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 101 MUL, 111 SLT.
- rsp_valid_0 / rsp_valid_1  out  1  response present for port 0 / 1.
- rsp_ready_0 / rsp_ready_1  in  1  requester accepts response.
- rsp_result  out  32  registered ALU result, shared by both ports.
- rsp_zero  out  1  registered zero flag (result == 0).
- illegal_op  out  1  one-cycle pulse: the executed opcode was 011 or 100.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state: IDLE.
- IDLE: arbitrate between valid requests. If only one is valid, grant it. If both are valid, grant the port named by prio. Assert req_ready_g combinationally for the granted port g only. On the handshake, latch a, b, op and owner=g, then go to EXEC. With no valid request, stay in IDLE.
- EXEC: drive the latched operands and op into the ALU. Register result into rsp_result and zero flag into rsp_zero. Pulse illegal_op if op is 011 or 100; in that case result=0 and zero=1. Go to RESP.
- RESP: assert rsp_valid_owner only; the other port's rsp_valid stays 0. rsp_result and rsp_zero hold stable until rsp_ready_owner=1. On the handshake, set prio = ~owner and go to IDLE.
- Width rules: ADD and SUB wrap modulo 2^32. MUL keeps the low 32 bits of the product. SLT is an unsigned compare, giving 1 or 0.
- The prio register changes only on response handshake.
- No request is ever dropped or reordered per port.
- req_ready_* is 0 in EXEC and RESP, and whenever rst=1.

## Timing
- Request accepted at edge N: EXEC during cycle N+1, rsp_valid high from cycle N+2.
- With rsp_ready held high, the response completes at the end of N+2. The next request can be accepted in cycle N+3.
- Minimum occupancy is 3 cycles per operation; maximum throughput is one op per 3 cycles.
- Responses are held indefinitely under backpressure. A request from the other port waits in IDLE arbitration and is not starved: after each completion, priority passes to the non-owner.
- Both ports valid at the same time: the port equal to prio wins, and the loser keeps req_valid asserted. The loser is granted next, after the winner's response handshake.
- Reset values: state=IDLE, prio=INIT_PRIORITY, rsp_valid_0/1=0, rsp_result=0, rsp_zero=0, illegal_op=0, req_ready_0/1=0.
- Reset in EXEC or RESP: the in-flight operation is discarded and no response is produced. rsp_valid drops in the cycle after the reset edge; the block is in IDLE at that cycle.
- Changing req_* inputs while req_ready=0 has no effect. Operands are sampled only on handshake.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams AND/OR/ADD/SUB/MUL/SLT;
  - a function flagging illegal opcodes;
  - FSM state encoding.
- One sub-module: the existing combinational ALU, instantiated once inside alu_arbiter. Its inputs come from the latched operand/op registers, not from the request ports.
- Arbitration and FSM stay in the top module; no further sub-modules.

## Test plan
- **Single op, no contention:** port 0 sends a=7, b=5, op=010, rsp_ready=1. Expected: req_ready_0 in the accept cycle, rsp_valid_0 two cycles later, rsp_result=12, rsp_zero=0. rsp_valid_1 stays 0 throughout.
- **Simultaneous requests, INIT_PRIORITY=0:** port 0 sends 3 SUB 3; port 1 sends 0xFFFF_FFFF ADD 1. Expected: port 0 first with result 0, zero=1. Then port 1 with result 0 (wrap), zero=1. Then both valid again: port 0 wins (prio moved to 0 after port 1 completed).
- **Backpressure:** port 1 sends 0x0001_0000 MUL 0x0001_0000 with rsp_ready_1=0 for 5 cycles. Expected: rsp_valid_1 and rsp_result=0 held stable for all 5 cycles. Port 0's request is not accepted until 1 cycle after the rsp_ready_1 handshake.
- **SLT and illegal op:** 2 SLT 9 gives result 1, zero=0. Op 011 gives result 0, zero=1, with illegal_op pulsing high for exactly one cycle (the EXEC cycle).
- **Reset mid-operation:** assert rst during EXEC. Expected: no rsp_valid ever appears for that op; all outputs take their reset values; prio=INIT_PRIORITY. A fresh request after reset completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, illegal-opcode check and FSM encoding for the ALU arbiter.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes 011 and 100 have no ALU function assigned.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b100);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU; undefined opcodes produce zero.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y
);

  // Result select; arithmetic wraps, MUL keeps the low word, SLT is unsigned.
  always_comb begin
    y = 32'd0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_SLT:  y = {31'd0, (a < b)};
      default: y = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit INIT_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_b_1,
  input  logic [2:0]  req_op_0,
  input  logic [2:0]  req_op_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        illegal_op
);

  state_t      state;
  logic        prio;
  logic        owner;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [31:0] alu_y;
  logic        grant;
  logic        accept;
  logic [2:0]  sel_op;
  logic        rsp_done;

  // Only the prio port wins a tie; a lone request is always granted.
  assign grant    = (req_valid_0 && req_valid_1) ? prio : req_valid_1;
  assign accept   = !rst && (state == ST_IDLE) && (req_valid_0 || req_valid_1);
  assign sel_op   = grant ? req_op_1 : req_op_0;
  assign rsp_done = owner ? rsp_ready_1 : rsp_ready_0;

  assign req_ready_0 = accept && !grant;
  assign req_ready_1 = accept && grant;

  alu_arbiter_alu u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  // Sequencer: latch on grant, compute once, hold response until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      prio        <= INIT_PRIORITY;
      owner       <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 3'd0;
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_zero    <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= grant;
            a_q   <= grant ? req_a_1 : req_a_0;
            b_q   <= grant ? req_b_1 : req_b_0;
            op_q  <= sel_op;
            // Raised on entry so the pulse spans exactly the EXEC cycle.
            illegal_op <= is_illegal_op(sel_op);
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          illegal_op <= 1'b0;
          if (is_illegal_op(op_q)) begin
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b1;
          end else begin
            rsp_result <= alu_y;
            rsp_zero   <= (alu_y == 32'd0);
          end
          rsp_valid_0 <= !owner;
          rsp_valid_1 <= owner;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_done) begin
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            prio        <= ~owner;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard-based bench for alu_arbiter (INIT_PRIORITY = 0).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [2:0]  req_op_0, req_op_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        illegal_op;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter #(.INIT_PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b101:  return a * b;
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t mk(input logic p, input logic [31:0] r);
    exp_t x;
    x.port = p;
    x.res  = r;
    x.zero = (r == 32'd0);
    return x;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", req_ready_0, req_ready_1);
    end
    @(negedge clk);
    rst = 1'b0; req_valid_0 = 1'b0; req_valid_1 = 1'b0; #1;
    checks++;
    if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b%b want 00", rsp_valid_0, rsp_valid_1);
    end
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got %h %b %b want 0 0 0", rsp_result, rsp_zero, illegal_op);
    end
  endtask

  task automatic test_single();
    req_valid_0 = 1'b1; req_a_0 = 32'd7; req_b_0 = 32'd5; req_op_0 = 3'b010;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1; #1;
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++; $display("FAIL single_grant got %b%b want 10", req_ready_0, req_ready_1);
    end
    sb.push_back(mk(1'b0, 32'd12));
    @(negedge clk);
    req_a_0 = 32'd99; #1;
    checks++;
    if (req_ready_0 !== 1'b0 || rsp_valid_0 !== 1'b0) begin
      errors++; $display("FAIL single_exec got ready=%b rsp_valid=%b want 0 0", req_ready_0, rsp_valid_0);
    end
    req_valid_0 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL single_rsp got v=%b%b res=%h z=%b want v=01 res=%h z=%b",
                         rsp_valid_1, rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0) begin
      errors++; $display("FAIL single_done got %b%b want 00", rsp_valid_1, rsp_valid_0);
    end
  endtask

  task automatic test_contention();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 32'd3; req_b_0 = 32'd3; req_op_0 = 3'b110;
    req_valid_1 = 1'b1; req_a_1 = 32'hFFFF_FFFF; req_b_1 = 32'd1; req_op_1 = 3'b010; #1;
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++; $display("FAIL cont_first got %b%b want 10", req_ready_0, req_ready_1);
    end
    sb.push_back(mk(1'b0, 32'd0));
    @(negedge clk); req_valid_0 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL cont_rsp0 got v=%b%b res=%h z=%b want v=01 res=%h z=%b",
                         rsp_valid_1, rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk);
    req_valid_0 = 1'b1; req_a_0 = 32'd1; req_b_0 = 32'd2; req_op_0 = 3'b001; #1;
    checks++;
    if (req_ready_1 !== 1'b1 || req_ready_0 !== 1'b0) begin
      errors++; $display("FAIL cont_second got %b%b want 01", req_ready_1, req_ready_0);
    end
    sb.push_back(mk(1'b1, 32'd0));
    @(negedge clk); req_a_1 = 32'd4; req_b_1 = 32'd6; req_op_1 = 3'b000;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_1 !== 1'b1 || rsp_valid_0 !== 1'b0 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL cont_rsp1 got v=%b%b res=%h z=%b want v=10 res=%h z=%b",
                         rsp_valid_1, rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++; $display("FAIL cont_rr got %b%b want 10", req_ready_0, req_ready_1);
    end
    sb.push_back(mk(1'b0, 32'd3));
    @(negedge clk); req_valid_0 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL cont_rsp0b got v=%b res=%h z=%b want v=1 res=%h z=%b",
                         rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready_1 !== 1'b1) begin
      errors++; $display("FAIL cont_loser got %b want 1", req_ready_1);
    end
    sb.push_back(mk(1'b1, 32'd4));
    @(negedge clk); req_valid_1 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_1 !== 1'b1 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL cont_rsp1b got v=%b res=%h z=%b want v=1 res=%h z=%b",
                         rsp_valid_1, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rsp_ready_1 = 1'b0;
    req_valid_1 = 1'b1; req_a_1 = 32'h0001_0000; req_b_1 = 32'h0001_0000; req_op_1 = 3'b101; #1;
    checks++;
    if (req_ready_1 !== 1'b1) begin
      errors++; $display("FAIL bp_grant got %b want 1", req_ready_1);
    end
    sb.push_back(mk(1'b1, 32'd0));
    @(negedge clk);
    req_valid_1 = 1'b0;
    req_valid_0 = 1'b1; req_a_0 = 32'd5; req_b_0 = 32'd5; req_op_0 = 3'b010;
    @(negedge clk);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rsp_valid_1 !== 1'b1 || rsp_valid_0 !== 1'b0 || rsp_result !== e.res ||
          rsp_zero !== e.zero || req_ready_0 !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b%b res=%h z=%b rdy0=%b want v=10 res=%h z=%b rdy0=0",
                           i, rsp_valid_1, rsp_valid_0, rsp_result, rsp_zero, req_ready_0, e.res, e.zero);
      end
      @(negedge clk);
    end
    rsp_ready_1 = 1'b1; #1;
    checks++;
    if (req_ready_0 !== 1'b0) begin
      errors++; $display("FAIL bp_early got %b want 0", req_ready_0);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready_0 !== 1'b1 || rsp_valid_1 !== 1'b0) begin
      errors++; $display("FAIL bp_after got rdy0=%b v1=%b want 1 0", req_ready_0, rsp_valid_1);
    end
    sb.push_back(mk(1'b0, 32'd10));
    @(negedge clk); req_valid_0 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL bp_rsp0 got v=%b res=%h z=%b want v=1 res=%h z=%b",
                         rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_slt_illegal();
    req_valid_0 = 1'b1; req_a_0 = 32'd2; req_b_0 = 32'd9; req_op_0 = 3'b111;
    sb.push_back(mk(1'b0, 32'd1));
    @(negedge clk); req_valid_0 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL slt got v=%b res=%h z=%b want v=1 res=%h z=%b",
                         rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk);
    req_valid_0 = 1'b1; req_a_0 = 32'd5; req_b_0 = 32'd6; req_op_0 = 3'b011; #1;
    checks++;
    if (req_ready_0 !== 1'b1 || illegal_op !== 1'b0) begin
      errors++; $display("FAIL ill_accept got rdy=%b ill=%b want 1 0", req_ready_0, illegal_op);
    end
    sb.push_back(mk(1'b0, 32'd0));
    @(negedge clk); req_valid_0 = 1'b0; #1;
    checks++;
    if (illegal_op !== 1'b1) begin
      errors++; $display("FAIL ill_exec got %b want 1", illegal_op);
    end
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (illegal_op !== 1'b0 || rsp_valid_0 !== 1'b1 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL ill_rsp got ill=%b v=%b res=%h z=%b want 0 1 %h %b",
                         illegal_op, rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    req_valid_1 = 1'b1; req_a_1 = 32'd10; req_b_1 = 32'd20; req_op_1 = 3'b010; #1;
    checks++;
    if (req_ready_1 !== 1'b1) begin
      errors++; $display("FAIL rm_grant got %b want 1", req_ready_1);
    end
    @(negedge clk);
    req_valid_1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    req_valid_0 = 1'b1; #1;
    checks++;
    if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0 || rsp_result !== 32'd0 ||
        rsp_zero !== 1'b0 || illegal_op !== 1'b0 || req_ready_0 !== 1'b0) begin
      errors++; $display("FAIL rm_reset got v=%b%b res=%h z=%b ill=%b rdy0=%b want 00 0 0 0 0",
                         rsp_valid_1, rsp_valid_0, rsp_result, rsp_zero, illegal_op, req_ready_0);
    end
    rst = 1'b0; req_valid_0 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_0 || rsp_valid_1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rm_ghost got rsp_valid seen=%b want 0", seen);
    end
    req_valid_0 = 1'b1; req_a_0 = 32'd1; req_b_0 = 32'd1; req_op_0 = 3'b010;
    req_valid_1 = 1'b1; #1;
    checks++;
    if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
      errors++; $display("FAIL rm_prio got %b%b want 10", req_ready_0, req_ready_1);
    end
    sb.push_back(mk(1'b0, 32'd2));
    @(negedge clk); req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (rsp_valid_0 !== 1'b1 || rsp_result !== e.res || rsp_zero !== e.zero) begin
      errors++; $display("FAIL rm_fresh got v=%b res=%h z=%b want v=1 res=%h z=%b",
                         rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c;
    rsp_ready_0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid_0 = 1'b1;
      req_a_0  = (k == 3) ? 32'hFFFF_FFF0 : $urandom;
      req_b_0  = (k == 5) ? req_a_0 : $urandom;
      req_op_0 = 3'(k);
      c = 0; #1;
      while (!req_ready_0 && c < 10) begin
        @(negedge clk); #1; c++;
      end
      checks++;
      if (req_ready_0 !== 1'b1 || (k > 0 && c != 0)) begin
        errors++; $display("FAIL b2b_accept[%0d] got rdy=%b waited=%0d want 1 0", k, req_ready_0, c);
      end
      sb.push_back(mk(1'b0, model(req_a_0, req_b_0, req_op_0)));
      @(negedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (rsp_valid_0 !== 1'b1 || rsp_result !== e.res || rsp_zero !== e.zero) begin
        errors++; $display("FAIL b2b_rsp[%0d] got v=%b res=%h z=%b want v=1 res=%h z=%b",
                           k, rsp_valid_0, rsp_result, rsp_zero, e.res, e.zero);
      end
      @(negedge clk);
    end
    req_valid_0 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    req_op_0 = '0; req_op_1 = '0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_slt_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
